csr_file: RTL and testbench

//  Machine-mode CSR file for the single-cycle NPC core; next generation of the basic mepc/mcause/mstatus/mtvec block.

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_counter64.sv | 26 ++
 rtl/csr_file.sv | 162 ++++++++++++++++
 tb/tb_csr_file.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// trap cause codes and the bit positions of the few writable status/enable bits.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_RW   = 3'd1,
        OP_RS   = 3'd2,
        OP_RC   = 3'd3,
        OP_RSV  = 3'd4,
        OP_RWI  = 3'd5,
        OP_RSI  = 3'd6,
        OP_RCI  = 3'd7
    } csr_op_e;

    // Low two op bits select the update kind; bit 2 selects the immediate source.
    localparam logic [1:0] OPK_NONE = 2'd0;
    localparam logic [1:0] OPK_RW   = 2'd1;
    localparam logic [1:0] OPK_RS   = 2'd2;
    localparam logic [1:0] OPK_RC   = 2'd3;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] MCAUSE_ECALL_M = 5'd11;
    localparam logic [4:0] MCAUSE_MEXT    = 5'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half loads; a load in a cycle
// takes precedence over the increment for the whole counter.
module csr_counter64 #(
    parameter int ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [63:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst || (ENABLE == 0)) begin
            count <= '0;
        end else if (ld_lo || ld_hi) begin
            if (ld_lo) count[31:0]  <= wdata[31:0];
            if (ld_hi) count[63:32] <= wdata[63:32];
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, ecall/external-interrupt trap
// entry, mret return, and the mcycle/minstret counters.
module csr_file #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RST    = XLEN'(32'h8000_0000),
    parameter int              HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MHARTID      = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      uimm,
    input  logic [XLEN-1:0] pc,
    input  logic            ecall,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_ext,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal
);
    import csr_pkg::*;

    localparam bit              HAS_HI     = (XLEN == 32);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mst_mie, mst_mpie, mie_meie, mip_meip;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
    logic [63:0]     mcycle, minstret, cnt_wdata;

    logic            op_active, wants_write, impl, read_only, int_p;
    logic            ecall_take, int_take, mret_take, trap_take, do_write;
    logic [XLEN-1:0] src, old_val, new_val, mstatus_val, mie_val, mip_val;

    assign op_active   = csr_op[1:0] != OPK_NONE;
    assign src         = csr_op[2] ? XLEN'(uimm) : rs1_data;
    // Set/clear with x0 (or uimm 0) is a pure read: no write, and no RO violation.
    assign wants_write = op_active && ((csr_op[1:0] == OPK_RW) || (uimm != 5'd0));

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE]  = mst_mie;
        mstatus_val[MSTATUS_MPIE] = mst_mpie;
        mie_val = '0;
        mie_val[MIE_MEIE] = mie_meie;
        mip_val = '0;
        mip_val[MIP_MEIP] = mip_meip;
    end

    always_comb begin
        old_val   = '0;
        impl      = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:   old_val = mstatus_val;
            CSR_MIE:       old_val = mie_val;
            CSR_MTVEC:     old_val = mtvec;
            CSR_MSCRATCH:  old_val = mscratch;
            CSR_MEPC:      old_val = mepc & ALIGN_MASK;
            CSR_MCAUSE:    old_val = mcause;
            CSR_MIP:       begin old_val = mip_val; read_only = 1'b1; end
            CSR_MCYCLE:    old_val = mcycle[XLEN-1:0];
            CSR_MINSTRET:  old_val = minstret[XLEN-1:0];
            CSR_MCYCLEH:   begin old_val = XLEN'(mcycle[63:32]);   impl = HAS_HI; end
            CSR_MINSTRETH: begin old_val = XLEN'(minstret[63:32]); impl = HAS_HI; end
            CSR_MHARTID:   begin old_val = MHARTID; read_only = 1'b1; end
            default:       impl = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op[1:0])
            OPK_RW:  new_val = src;
            OPK_RS:  new_val = old_val | src;
            OPK_RC:  new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    assign illegal = op_active && (!impl || (read_only && wants_write));

    // One event per cycle, ecall > interrupt > mret; an illegal op blocks all of them.
    assign int_p      = mst_mie & mie_meie & mip_meip;
    assign ecall_take = ecall && !illegal;
    assign int_take   = int_p && !illegal && !ecall;
    assign mret_take  = mret && !illegal && !ecall && !int_p;
    assign trap_take  = ecall_take || int_take;
    assign do_write   = wants_write && !illegal && !int_take;

    assign csr_rdata   = (op_active && !illegal) ? old_val : '0;
    assign redirect    = trap_take || mret_take;
    assign redirect_pc = trap_take ? (mtvec & ALIGN_MASK) :
                         mret_take ? (mepc & ALIGN_MASK)  : '0;

    always_comb begin
        if (HAS_HI) cnt_wdata = {2{new_val[31:0]}};
        else        cnt_wdata = 64'(new_val);
    end

    csr_counter64 #(.ENABLE(HAS_COUNTERS)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .ld_lo (do_write && (csr_addr == CSR_MCYCLE)),
        .ld_hi (do_write && ((csr_addr == CSR_MCYCLEH) || (!HAS_HI && (csr_addr == CSR_MCYCLE)))),
        .wdata (cnt_wdata),
        .count (mcycle)
    );

    csr_counter64 #(.ENABLE(HAS_COUNTERS)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && !trap_take),
        .ld_lo (do_write && (csr_addr == CSR_MINSTRET)),
        .ld_hi (do_write && ((csr_addr == CSR_MINSTRETH) || (!HAS_HI && (csr_addr == CSR_MINSTRET)))),
        .wdata (cnt_wdata),
        .count (minstret)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
            mie_meie <= 1'b0;
            mip_meip <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            mip_meip <= irq_ext;
            if (do_write) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mst_mie  <= new_val[MSTATUS_MIE];
                        mst_mpie <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_meie <= new_val[MIE_MEIE];
                    CSR_MTVEC:    mtvec    <= new_val;
                    CSR_MSCRATCH: mscratch <= new_val;
                    CSR_MEPC:     mepc     <= new_val;
                    CSR_MCAUSE:   mcause   <= new_val;
                    default: ;
                endcase
            end
            // Trap/return status updates override any same-cycle mstatus write.
            if (trap_take) begin
                mepc     <= pc;
                mcause   <= int_take ? {1'b1, (XLEN-1)'(MCAUSE_MEXT)} : XLEN'(MCAUSE_ECALL_M);
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_take) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Table-driven bench for csr_file: each vector is one instruction cycle; its
// expected outputs go to a scoreboard and are compared at the following negedge.
module tb_csr_file;
    import csr_pkg::*;

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic [31:0] pc;
        logic [3:0]  ev;     // {irq_ext, retire, mret, ecall}
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ill;
    } vec_t;

    localparam logic [3:0] E_NO = 4'b0000;
    localparam logic [3:0] E_EC = 4'b0001;
    localparam logic [3:0] E_MR = 4'b0010;
    localparam logic [3:0] E_RT = 4'b0100;
    localparam logic [3:0] E_IQ = 4'b1000;
    localparam logic [31:0] VEC = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  uimm;
    logic [31:0] pc;
    logic        ecall, mret, retire, irq_ext;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[$];

    csr_file dut (
        .clk         (clk),
        .rst         (rst),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .rs1_data    (rs1_data),
        .uimm        (uimm),
        .pc          (pc),
        .ecall       (ecall),
        .mret        (mret),
        .retire      (retire),
        .irq_ext     (irq_ext),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] rs1, input logic [4:0] ui,
                                input logic [31:0] pcv, input logic [3:0] ev,
                                input logic [31:0] rd, input logic rdir,
                                input logic [31:0] rpc, input logic ill);
        vec_t v;
        v.id = 0; v.op = op; v.addr = addr; v.rs1 = rs1; v.uimm = ui; v.pc = pcv; v.ev = ev;
        v.rdata = rd; v.redir = rdir; v.rpc = rpc; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string what, input int id, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", what, id, got, want);
        end
    endtask

    task automatic step(input vec_t v, input bit check);
        csr_op   = v.op;
        csr_addr = v.addr;
        rs1_data = v.rs1;
        uimm     = v.uimm;
        pc       = v.pc;
        ecall    = v.ev[0];
        mret     = v.ev[1];
        retire   = v.ev[2];
        irq_ext  = v.ev[3];
        if (check) sb.push_back(v);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata",       e.id, csr_rdata,   e.rdata);
            chk("redirect",    e.id, {31'd0, redirect}, {31'd0, e.redir});
            chk("redirect_pc", e.id, redirect_pc, e.rpc);
            chk("illegal",     e.id, {31'd0, illegal},  {31'd0, e.ill});
        end
    end

    initial begin
        vec_t v;
        // c0..c8: reset values and cycle counter
        tbl.push_back(mk(OP_RS,   CSR_MCYCLE,   0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MTVEC,    0, 0, 0, E_NO, 32'h8000_0000, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSTATUS,  0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RSI,  CSR_MSCRATCH, 0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MCAUSE,   0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MINSTRET, 0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RSV,  CSR_MTVEC,    0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_NONE, 12'h7C0,      0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MCYCLE,   0, 0, 0, E_NO, 32'd8, 0, 0, 0));
        // c9..c15: RW/RS/RC with register and immediate sources
        tbl.push_back(mk(OP_RW,  CSR_MSCRATCH, 32'hDEAD_BEEF, 1, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,  CSR_MSCRATCH, 32'hFFFF_FFFF, 0, 0, E_NO, 32'hDEAD_BEEF, 0, 0, 0));
        tbl.push_back(mk(OP_RC,  CSR_MSCRATCH, 32'h0000_FFFF, 2, 0, E_NO, 32'hDEAD_BEEF, 0, 0, 0));
        tbl.push_back(mk(OP_RSI, CSR_MSCRATCH, 0, 0, 0, E_NO, 32'hDEAD_0000, 0, 0, 0));
        tbl.push_back(mk(OP_RWI, CSR_MSCRATCH, 0, 5'h1F, 0, E_NO, 32'hDEAD_0000, 0, 0, 0));
        tbl.push_back(mk(OP_RCI, CSR_MSCRATCH, 0, 5'h03, 0, E_NO, 32'h1F, 0, 0, 0));
        tbl.push_back(mk(OP_RS,  CSR_MSCRATCH, 0, 0, 0, E_NO, 32'h1C, 0, 0, 0));
        // c16..c27: ecall, mret, mepc alignment
        tbl.push_back(mk(OP_RW,   CSR_MTVEC,   32'h8000_0103, 1, 0, E_NO, 32'h8000_0000, 0, 0, 0));
        tbl.push_back(mk(OP_RSI,  CSR_MSTATUS, 0, 5'd8, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MTVEC,   0, 0, 0, E_NO, 32'h8000_0103, 0, 0, 0));
        tbl.push_back(mk(OP_NONE, 12'h0, 0, 0, 32'h8000_0040, E_EC | E_RT, 32'h0, 1, VEC, 0));
        tbl.push_back(mk(OP_RS,   CSR_MEPC,    0, 0, 0, E_NO, 32'h8000_0040, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MCAUSE,  0, 0, 0, E_NO, 32'd11, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSTATUS, 0, 0, 0, E_NO, 32'h80, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSTATUS, 0, 0, 0, E_MR | E_RT, 32'h80, 1, 32'h8000_0040, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSTATUS, 0, 0, 0, E_NO, 32'h88, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MINSTRET, 0, 0, 0, E_NO, 32'd1, 0, 0, 0));
        tbl.push_back(mk(OP_RW,   CSR_MEPC,    32'h1237, 1, 0, E_NO, 32'h8000_0040, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MEPC,    0, 0, 0, E_NO, 32'h1234, 0, 0, 0));
        // c28..c40: external interrupt, priorities, suppressed write
        tbl.push_back(mk(OP_RW,   CSR_MIE,     32'hFFFF_FFFF, 1, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MIE,     0, 0, 0, E_IQ, 32'h800, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MIP,     0, 0, 32'h8000_0200, E_IQ | E_RT, 32'h800, 1, VEC, 0));
        tbl.push_back(mk(OP_RS,   CSR_MCAUSE,  0, 0, 0, E_IQ, 32'h8000_000B, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MEPC,    0, 0, 0, E_IQ, 32'h8000_0200, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSTATUS, 0, 0, 0, E_IQ, 32'h80, 0, 0, 0));
        tbl.push_back(mk(OP_RSI,  CSR_MSTATUS, 0, 5'd8, 0, E_IQ, 32'h80, 0, 0, 0));
        tbl.push_back(mk(OP_NONE, 12'h0, 0, 0, 32'h8000_0300, E_IQ | E_EC, 32'h0, 1, VEC, 0));
        tbl.push_back(mk(OP_RS,   CSR_MCAUSE,  0, 0, 0, E_IQ, 32'd11, 0, 0, 0));
        tbl.push_back(mk(OP_RSI,  CSR_MSTATUS, 0, 5'd8, 0, E_IQ, 32'h80, 0, 0, 0));
        tbl.push_back(mk(OP_RW,   CSR_MSCRATCH, 32'h5555, 1, 32'h8000_0400, E_IQ | E_MR, 32'h1C, 1, VEC, 0));
        tbl.push_back(mk(OP_RS,   CSR_MSCRATCH, 0, 0, 0, E_NO, 32'h1C, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MIP,     0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        // c41..c50: illegal accesses block writes and traps
        tbl.push_back(mk(OP_RW,   CSR_MHARTID, 32'h1234, 1, 0, E_NO, 32'h0, 0, 0, 1));
        tbl.push_back(mk(OP_RW,   CSR_MIP,     32'hFFFF, 1, 0, E_NO, 32'h0, 0, 0, 1));
        tbl.push_back(mk(OP_RS,   CSR_MIP,     32'hFFFF, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RSI,  CSR_MHARTID, 0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   12'h7C0,     0, 0, 0, E_NO, 32'h0, 0, 0, 1));
        tbl.push_back(mk(OP_RSI,  CSR_MHARTID, 0, 1, 0, E_NO, 32'h0, 0, 0, 1));
        tbl.push_back(mk(OP_RW,   CSR_MHARTID, 32'h1, 1, 32'h8000_0500, E_EC, 32'h0, 0, 0, 1));
        tbl.push_back(mk(OP_RS,   CSR_MCAUSE,  0, 0, 0, E_NO, 32'h8000_000B, 0, 0, 0));
        tbl.push_back(mk(OP_RS,   CSR_MEPC,    0, 0, 0, E_NO, 32'h8000_0400, 0, 0, 0));
        tbl.push_back(mk(OP_NONE, CSR_MEPC,    0, 0, 32'h8000_0600, E_NO, 32'h0, 0, 0, 0));
        // c51..c67: counter half writes, write-beats-increment, 64-bit wrap
        tbl.push_back(mk(OP_RW, CSR_MCYCLE,  32'hFFFF_FFFF, 1, 0, E_NO, 32'd51, 0, 0, 0));
        tbl.push_back(mk(OP_RW, CSR_MCYCLEH, 32'h0, 1, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLE,  0, 0, 0, E_NO, 32'hFFFF_FFFF, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLE,  0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLEH, 0, 0, 0, E_NO, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RW, CSR_MCYCLE,  32'h100, 1, 0, E_NO, 32'h2, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLE,  0, 0, 0, E_NO, 32'h100, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLEH, 0, 0, 0, E_NO, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RW, CSR_MCYCLEH, 32'hFFFF_FFFF, 1, 0, E_NO, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RW, CSR_MCYCLE,  32'hFFFF_FFFF, 1, 0, E_NO, 32'h102, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLE,  0, 0, 0, E_NO, 32'hFFFF_FFFF, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLEH, 0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MCYCLE,  0, 0, 0, E_NO, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RW, CSR_MINSTRET, 32'hFFFF_FFFF, 1, 0, E_RT, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MINSTRET, 0, 0, 0, E_RT, 32'hFFFF_FFFF, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MINSTRETH, 0, 0, 0, E_NO, 32'h1, 0, 0, 0));
        tbl.push_back(mk(OP_RS, CSR_MINSTRET, 0, 0, 0, E_NO, 32'h0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) tbl[i].id = i;

        // Reset: idle outputs, then reset must win over ecall/write/retire/irq
        rst = 1'b1;
        v = mk(OP_NONE, 12'h0, 0, 0, 0, E_NO, 0, 0, 0, 0);
        step(v, 1'b0);
        step(v, 1'b0);
        v.id = 1000;
        step(v, 1'b1);
        step(mk(OP_RW, CSR_MSCRATCH, 32'h1234, 1, 32'h8000_0010, E_EC | E_RT | E_IQ, 0, 0, 0, 0), 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        // Mid-run reset with a pending write and ecall restores every register
        rst = 1'b1;
        step(mk(OP_RW, CSR_MSCRATCH, 32'hABCD, 1, 32'h8000_0700, E_EC | E_RT, 0, 0, 0, 0), 1'b0);
        rst = 1'b0;
        v = mk(OP_RS, CSR_MCYCLE,   0, 0, 0, E_NO, 32'h0, 0, 0, 0);           v.id = 2000; step(v, 1'b1);
        v = mk(OP_RS, CSR_MSCRATCH, 0, 0, 0, E_NO, 32'h0, 0, 0, 0);           v.id = 2001; step(v, 1'b1);
        v = mk(OP_RS, CSR_MTVEC,    0, 0, 0, E_NO, 32'h8000_0000, 0, 0, 0);   v.id = 2002; step(v, 1'b1);
        v = mk(OP_RS, CSR_MSTATUS,  0, 0, 0, E_NO, 32'h0, 0, 0, 0);           v.id = 2003; step(v, 1'b1);
        v = mk(OP_RS, CSR_MCAUSE,   0, 0, 0, E_NO, 32'h0, 0, 0, 0);           v.id = 2004; step(v, 1'b1);
        v = mk(OP_RS, CSR_MINSTRETH, 0, 0, 0, E_NO, 32'h0, 0, 0, 0);          v.id = 2005; step(v, 1'b1);

        step(mk(OP_NONE, 12'h0, 0, 0, 0, E_NO, 0, 0, 0, 0), 1'b0);
        chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
